chunked_ripple_accumulator: RTL

Parametrised multi-cycle accumulator and the successor to the lab-4 switch-driven adder. Each edge-detected Run_Accumulate press adds the switch operand SW into a running sum. The add runs DIGIT_W bits per clock over WIDTH/DIGIT_W cycles, as a time-multiplexed ripple adder. Sum and CO feed the board's hex/LED display logic; wrap or saturate is selected by parameter.

---
 rtl/chunked_ripple_accumulator_if.sv | 29 ++
 rtl/chunked_ripple_accumulator.sv | 135 +++++++++++++
 2 files changed

// File: rtl/chunked_ripple_accumulator_if.sv
// +-------------------------------------------------------------------------+
// | chunked_ripple_accumulator_if : run/clear/operand bus and result bus     |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

interface chunked_ripple_accumulator_if #(
   parameter int WIDTH = 16
);
   logic             Run_Accumulate;
   logic             Clear_Acc;
   logic [WIDTH-1:0] SW;
   logic [WIDTH-1:0] Sum;
   logic             CO;
   logic             Busy;
   logic             Done;

   modport master (
      output Run_Accumulate, Clear_Acc, SW,
      input  Sum, CO, Busy, Done
   );

   modport slave (
      input  Run_Accumulate, Clear_Acc, SW,
      output Sum, CO, Busy, Done
   );
endinterface

`default_nettype wire

// File: rtl/chunked_ripple_accumulator.sv
// +-------------------------------------------------------------------------+
// | chunked_ripple_accumulator : button-driven accumulator, DIGIT_W bits/clk |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module chunked_ripple_accumulator #(
   parameter int WIDTH    = 16,
   parameter int DIGIT_W  = 4,
   parameter int SATURATE = 0
) (
   input  logic                          Clk,
   input  logic                          Reset_Clear,
   chunked_ripple_accumulator_if.slave   bus
);
   localparam int N     = WIDTH / DIGIT_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               run_q, run_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               co_q, co_d;
   logic               done_q, done_d;

   logic               start;
   logic [DIGIT_W:0]   slice;
   logic [WIDTH-1:0]   slice_ext;

   always_ff @(posedge Clk or negedge Reset_Clear) begin
      if (!Reset_Clear) begin
         state_q <= IDLE;
         run_q   <= 1'b1;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      run_d     = bus.Run_Accumulate;
      idx_d     = idx_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      sum_d     = sum_q;
      co_d      = co_q;
      done_d    = 1'b0;

      start     = run_q & ~bus.Run_Accumulate;
      slice     = {1'b0, a_q[DIGIT_W-1:0]} + {1'b0, b_q[DIGIT_W-1:0]}
                + {{DIGIT_W{1'b0}}, carry_q};
      slice_ext = WIDTH'(slice[DIGIT_W-1:0]);

      // Clear outranks everything, including a start on the same edge.
      if (bus.Clear_Acc) begin
         state_d = IDLE;
         sum_d   = '0;
         co_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_d     = sum_q;
                  b_d     = bus.SW;
                  carry_d = 1'b0;
                  idx_d   = '0;
                  state_d = ADD;
               end
            end
            ADD: begin
               // Result slices enter at the top and drift down, LSB slice first.
               a_d     = a_q >> DIGIT_W;
               b_d     = b_q >> DIGIT_W;
               res_d   = (res_q >> DIGIT_W) | (slice_ext << (WIDTH - DIGIT_W));
               carry_d = slice[DIGIT_W];
               idx_d   = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = FINISH;
               end
            end
            FINISH: begin
               if ((SATURATE != 0) && carry_q) begin
                  sum_d = '1;
               end else begin
                  sum_d = res_q;
               end
               co_d    = carry_q;
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.Sum  = sum_q;
   assign bus.CO   = co_q;
   assign bus.Busy = (state_q != IDLE);
   assign bus.Done = done_q;

endmodule

`default_nettype wire
